// File: rtl/fm_radio_pkg.sv
// Shared FM radio definitions: demodulator states, Q10 fixed-point helpers.
// Also consumed by the arctan stage.
package fm_radio_pkg;

  localparam int          QUANT_BITS   = 10;
  localparam logic [31:0] DEFAULT_GAIN = 32'h000002F6;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    ISSUE,
    WAIT,
    GAIN_S,
    OUT
  } demod_state_t;

  // Arithmetic shift that truncates toward zero: negative values get a bias first.
  function automatic logic signed [31:0] dequantize(input logic signed [31:0] v);
    logic signed [31:0] t;
    t = v[31] ? v + 32'sd1023 : v;
    return t >>> QUANT_BITS;
  endfunction

  function automatic logic signed [31:0] quantize(input logic signed [31:0] v);
    return v <<< QUANT_BITS;
  endfunction

endpackage

// File: rtl/fm_demod_cmul.sv
// Registered conjugate multiply conj(prev) * cur, dequantized back to Q10.
module fm_demod_cmul
  import fm_radio_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic signed [31:0] prev_i,
  input  logic signed [31:0] prev_q,
  input  logic signed [31:0] cur_i,
  input  logic signed [31:0] cur_q,
  output logic signed [31:0] x,
  output logic signed [31:0] y
);

  logic signed [63:0] x_full, y_full;

  always_comb begin
    x_full = 64'(prev_i) * 64'(cur_i) + 64'(prev_q) * 64'(cur_q);
    y_full = 64'(prev_i) * 64'(cur_q) - 64'(prev_q) * 64'(cur_i);
  end

  // Only the low word is kept; wraparound is intentional.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      x <= dequantize(x_full[31:0]);
      y <= dequantize(y_full[31:0]);
    end
  end

endmodule

// File: rtl/fm_demod_front.sv
// FM demodulator front end: conjugate multiply, arctan handshake, gain stage.
// Optional FM_DEMOD_SAT_EN clamps the output to the signed 16-bit range.
module fm_demod_front
  import fm_radio_pkg::*;
#(
  parameter logic [31:0] GAIN = DEFAULT_GAIN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_in,
  input  logic [31:0] q_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] x_out,
  output logic [31:0] y_out,
  output logic        demod_data_valid,
  input  logic        qarctan_done,
  input  logic [31:0] angle_in,
  output logic [31:0] demod_out,
  output logic        out_valid,
  input  logic        out_ready
);

  demod_state_t       state, state_nxt;
  logic signed [31:0] cur_i, cur_q, prev_i, prev_q, angle, result, x_s, y_s;
  logic signed [63:0] gain_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MULT;
      MULT:    state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (qarctan_done) state_nxt = GAIN_S;
      GAIN_S:  state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready         = (state == IDLE);
  assign demod_data_valid = (state == ISSUE);
  assign out_valid        = (state == OUT);

  always_comb begin
    gain_full = 64'(angle) * 64'($signed(GAIN));
    result    = dequantize(gain_full[31:0]);
`ifdef FM_DEMOD_SAT_EN
    if (result > 32'sd32767)       result = 32'sd32767;
    else if (result < -32'sd32768) result = -32'sd32768;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_i     <= '0;
      cur_q     <= '0;
      prev_i    <= '0;
      prev_q    <= '0;
      angle     <= '0;
      demod_out <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        cur_i <= i_in;
        cur_q <= q_in;
      end
      if (state == MULT) begin
        prev_i <= cur_i;
        prev_q <= cur_q;
      end
      if (state == WAIT && qarctan_done) angle <= angle_in;
      if (state == GAIN_S) demod_out <= result;
    end
  end

  // x/y only move in MULT, so they stay stable for the arctan stage through WAIT.
  fm_demod_cmul u_cmul (
    .clk    (clk),
    .reset  (reset),
    .en     (state == MULT),
    .prev_i (prev_i),
    .prev_q (prev_q),
    .cur_i  (cur_i),
    .cur_q  (cur_q),
    .x      (x_s),
    .y      (y_s)
  );

  assign x_out = x_s;
  assign y_out = y_s;

endmodule
